// File: rtl/mips_if_stage.sv
// Instruction-fetch stage: PC, instruction-memory request and IF/ID register.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module mips_if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] IF_pc4,
   output logic [31:0] IF_instr,
   output logic        IF_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;
   logic        r_run;
   logic [31:0] r_pc, w_pc_nxt;
   logic [31:0] r_pend, w_pend_nxt;
   logic [31:0] r_buf, w_buf_nxt;
   logic [31:0] r_pc4, w_pc4_nxt;
   logic [31:0] r_instr, w_instr_nxt;
   logic        r_valid, w_valid_nxt;
   logic        w_load;
   logic [31:0] w_load_instr;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_rpc;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_rpc      = redirect_pc & 32'hFFFF_FFFC;

   // r_run keeps the request low until the first edge after reset release
   assign imem_req  = r_run & (r_state != HOLD);
   assign imem_addr = r_pc;
   assign IF_pc4    = r_pc4;
   assign IF_instr  = r_instr;
   assign IF_valid  = r_valid;

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_pend_nxt   = r_pend;
      w_buf_nxt    = r_buf;
      w_pc4_nxt    = r_pc4;
      w_instr_nxt  = r_instr;
      w_valid_nxt  = r_valid;
      w_load       = 1'b0;
      w_load_instr = imem_rdata;

      if (r_run) begin
         case (r_state)
            FETCH: begin
               if (redirect && imem_ready) begin
                  w_pc_nxt    = w_rpc;
                  w_valid_nxt = 1'b0;
               end else if (redirect) begin
                  w_pend_nxt  = w_rpc;
                  w_valid_nxt = 1'b0;
                  w_state_nxt = DROP;
               end else if (imem_ready && !stall) begin
                  w_load   = 1'b1;
                  w_pc_nxt = w_pc_plus4;
               end else if (imem_ready) begin
                  w_buf_nxt   = imem_rdata;
                  w_state_nxt = HOLD;
               end else if (!stall) begin
                  w_valid_nxt = 1'b0;
               end
            end
            HOLD: begin
               if (redirect) begin
                  w_pc_nxt    = w_rpc;
                  w_valid_nxt = 1'b0;
                  w_state_nxt = FETCH;
               end else if (!stall) begin
                  w_load       = 1'b1;
                  w_load_instr = r_buf;
                  w_pc_nxt     = w_pc_plus4;
                  w_state_nxt  = FETCH;
               end
            end
            DROP: begin
               w_valid_nxt = 1'b0;
               // A redirect arriving with the stale response still wins
               if (imem_ready) begin
                  w_pc_nxt    = redirect ? w_rpc : r_pend;
                  w_state_nxt = FETCH;
               end else if (redirect) begin
                  w_pend_nxt = w_rpc;
               end
            end
            default: w_state_nxt = FETCH;
         endcase
      end

      if (w_load) begin
         w_pc4_nxt   = w_pc_plus4;
         w_instr_nxt = w_load_instr;
         w_valid_nxt = 1'b1;
      end

      if (flush) begin
         w_pc4_nxt   = r_pc4;
         w_instr_nxt = NOP_INSTR;
         w_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= FETCH;
         r_run   <= 1'b0;
         r_pc    <= RESET_PC;
         r_pend  <= 32'd0;
         r_buf   <= 32'd0;
         r_pc4   <= 32'd0;
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= 1'b1;
         r_pc    <= w_pc_nxt;
         r_pend  <= w_pend_nxt;
         r_buf   <= w_buf_nxt;
         r_pc4   <= w_pc4_nxt;
         r_instr <= w_instr_nxt;
         r_valid <= w_valid_nxt;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_stall_cnt;
   logic        w_fetch_inc;

   assign w_fetch_inc    = w_load & ~flush;
   assign perf_fetch_cnt = r_fetch_cnt;
   assign perf_stall_cnt = r_stall_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_cnt <= 32'd0;
         r_stall_cnt <= 32'd0;
      end else begin
         if (w_fetch_inc) r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (stall)       r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end
`else
   // Counters absent: the stage carries no performance state.
`endif

endmodule

// File: tb/tb_mips_if_stage.sv
// Directed bench for mips_if_stage: memory returns addr ^ 32'hA5A5_0000.
module tb_mips_if_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] IF_pc4;
   logic [31:0] IF_instr;
   logic        IF_valid;

   int n_chk;
   int n_fail;

   mips_if_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .flush       (flush),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ready  (imem_ready),
      .IF_pc4      (IF_pc4),
      .IF_instr    (IF_instr),
      .IF_valid    (IF_valid)
   );

   assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_chk       = 0;
      n_fail      = 0;
      reset       = 1'b0;
      stall       = 1'b0;
      flush       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      imem_ready  = 1'b1;

      step();
      step();
      chk("rst_req",   {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, IF_valid}, 32'd0);
      chk("rst_pc4",   IF_pc4,            32'd0);
      chk("rst_instr", IF_instr,          32'd0);
      chk("rst_addr",  imem_addr,         32'd0);

      // 1: streaming fetch with zero-wait memory
      reset = 1'b1;
      step();
      chk("t1_req",    {31'd0, imem_req}, 32'd1);
      chk("t1_addr0",  imem_addr,         32'h0);
      chk("t1_valid0", {31'd0, IF_valid}, 32'd0);
      step();
      chk("t1_pc4_4",  IF_pc4,            32'h4);
      chk("t1_instr0", IF_instr,          32'hA5A5_0000);
      chk("t1_valid1", {31'd0, IF_valid}, 32'd1);
      chk("t1_addr4",  imem_addr,         32'h4);
      step();
      chk("t1_pc4_8",  IF_pc4,            32'h8);
      chk("t1_addr8",  imem_addr,         32'h8);

      // 2: three wait states at pc=0x8
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_addr",  imem_addr,         32'h8);
         chk("t2_valid", {31'd0, IF_valid}, 32'd0);
         chk("t2_req",   {31'd0, imem_req}, 32'd1);
      end
      imem_ready = 1'b1;
      step();
      chk("t2_pc4",   IF_pc4,            32'hC);
      chk("t2_instr", IF_instr,          32'hA5A5_0008);
      chk("t2_vld",   {31'd0, IF_valid}, 32'd1);
      step();
      chk("t2_addr10", imem_addr,        32'h10);

      // 3: two-cycle stall with the word already returned at pc=0x10
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("t3_req0",  {31'd0, imem_req}, 32'd0);
         chk("t3_pc4",   IF_pc4,            32'h10);
         chk("t3_instr", IF_instr,          32'hA5A5_000C);
      end
      stall = 1'b0;
      step();
      chk("t3_pc4_rel",   IF_pc4,            32'h14);
      chk("t3_instr_rel", IF_instr,          32'hA5A5_0010);
      chk("t3_valid_rel", {31'd0, IF_valid}, 32'd1);
      chk("t3_addr_rel",  imem_addr,         32'h14);
      chk("t3_req_rel",   {31'd0, imem_req}, 32'd1);
      step();
      chk("t3_pc4_18", IF_pc4,   32'h18);
      chk("t3_ins_18", IF_instr, 32'hA5A5_0014);
      step();
      step();
      chk("t3_addr20", imem_addr, 32'h20);

      // 4: redirect while the 0x20 response is outstanding
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      imem_ready  = 1'b0;
      step();
      chk("t4_valid_a", {31'd0, IF_valid}, 32'd0);
      chk("t4_addr_a",  imem_addr,         32'h20);
      chk("t4_req_a",   {31'd0, imem_req}, 32'd1);
      redirect = 1'b0;
      step();
      chk("t4_valid_b", {31'd0, IF_valid}, 32'd0);
      chk("t4_addr_b",  imem_addr,         32'h20);
      imem_ready = 1'b1;
      step();
      chk("t4_valid_c", {31'd0, IF_valid}, 32'd0);
      chk("t4_addr_c",  imem_addr,         32'h100);
      step();
      chk("t4_pc4",   IF_pc4,            32'h104);
      chk("t4_instr", IF_instr,          32'hA5A5_0100);
      chk("t4_valid", {31'd0, IF_valid}, 32'd1);

      // 5: redirect to the top of the address space, pc+4 wraps
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      chk("t5_addr_top", imem_addr,         32'hFFFF_FFFC);
      chk("t5_valid0",   {31'd0, IF_valid}, 32'd0);
      redirect = 1'b0;
      step();
      chk("t5_pc4_wrap", IF_pc4,            32'h0);
      chk("t5_instr",    IF_instr,          32'h5A5A_FFFC);
      chk("t5_valid1",   {31'd0, IF_valid}, 32'd1);
      chk("t5_addr0",    imem_addr,         32'h0);

      // flush overrides the load, pc keeps advancing
      flush = 1'b1;
      step();
      chk("fl_valid", {31'd0, IF_valid}, 32'd0);
      chk("fl_instr", IF_instr,          32'h0);
      chk("fl_pc4",   IF_pc4,            32'h0);
      chk("fl_addr",  imem_addr,         32'h4);
      flush = 1'b0;

      // redirect target low bits are ignored
      redirect    = 1'b1;
      redirect_pc = 32'h203;
      step();
      chk("rd_align", imem_addr, 32'h200);
      redirect = 1'b0;
      step();
      chk("rd_pc4",   IF_pc4,   32'h204);
      chk("rd_instr", IF_instr, 32'hA5A5_0200);

      // 6: reset asserted while in HOLD
      stall = 1'b1;
      step();
      chk("t6_hold_req", {31'd0, imem_req}, 32'd0);
      chk("t6_hold_vld", {31'd0, IF_valid}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("t6_rst_vld", {31'd0, IF_valid}, 32'd0);
      chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
      chk("t6_rst_pc4", IF_pc4,            32'd0);
      stall = 1'b0;
      step();
      chk("t6_held_req", {31'd0, imem_req}, 32'd0);
      reset = 1'b1;
      step();
      chk("t6_req",  {31'd0, imem_req}, 32'd1);
      chk("t6_addr", imem_addr,         32'h0);
      step();
      chk("t6_pc4",   IF_pc4,            32'h4);
      chk("t6_valid", {31'd0, IF_valid}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
